// File: rtl/psp_rvfi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psp_rvfi_pkg
// Description : Shared RVFI retire record type and order-tag width.
// Revision    : 1.0 - initial release
// ============================================================================
package psp_rvfi_pkg;

  localparam int RVFI_ORDER_W = 64;

  // One retirement as seen by the RVFI consumer (311 bits).
  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_pkt_t;

endpackage : psp_rvfi_pkg
`default_nettype wire

// File: rtl/rvfi_pkt_normalise.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_pkt_normalise
// Description : Zeroes data fields that RVFI defines as meaningless: rd_wdata
//               for writes to x0, and memory data whose byte mask is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module rvfi_pkt_normalise
  import psp_rvfi_pkg::*;
(
  input  rvfi_pkt_t pkt_in,
  output rvfi_pkt_t pkt_out
);

  // Copy everything, then clear the fields that carry no architectural value.
  always_comb begin
    pkt_out = pkt_in;
    if (pkt_in.rd_addr == 5'd0)   pkt_out.rd_wdata  = '0;
    if (pkt_in.mem_rmask == 4'd0) pkt_out.mem_rdata = '0;
    if (pkt_in.mem_wmask == 4'd0) pkt_out.mem_wdata = '0;
  end

endmodule : rvfi_pkt_normalise
`default_nettype wire

// File: rtl/rvfi_retire_buffer.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_retire_buffer
// Description : Order-tagging, normalising retire FIFO between the writeback
//               stage and the RVFI consumer, with sticky drop detection.
// Revision    : 1.0 - initial release
// ============================================================================
module rvfi_retire_buffer
  import psp_rvfi_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    retire_valid,
  input  rvfi_pkt_t               retire_pkt,
  output logic                    retire_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output rvfi_pkt_t               out_pkt,
  output logic [RVFI_ORDER_W-1:0] out_order,
  output logic [CNT_W-1:0]        count,
  output logic                    overflow,
  output logic [15:0]             drop_count
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  rvfi_pkt_t               r_mem       [DEPTH];
  logic [RVFI_ORDER_W-1:0] r_mem_order [DEPTH];
  logic [PTR_W-1:0]        r_wptr;
  logic [PTR_W-1:0]        r_rptr;
  logic [CNT_W-1:0]        r_count;
  logic [RVFI_ORDER_W-1:0] r_order;
  logic                    r_overflow;
  logic [15:0]             r_drop_count;

  rvfi_pkt_t w_norm_pkt;
  logic      w_push;
  logic      w_pop;
  logic      w_drop;

  rvfi_pkt_normalise u_normalise (
    .pkt_in  (retire_pkt),
    .pkt_out (w_norm_pkt)
  );

  // Handshake decode; the out_ready term lets a full buffer accept while popping.
  always_comb begin
    retire_ready = (r_count < C_DEPTH) || out_ready;
    out_valid    = (r_count != '0);
    w_push       = retire_valid && retire_ready;
    w_pop        = out_valid && out_ready;
    w_drop       = retire_valid && !retire_ready;
  end

  // Control state: pointers, occupancy and order tag; flush wins over push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_order <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr  <= r_wptr + PTR_W'(1);
        r_order <= r_order + RVFI_ORDER_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Drop tracking survives flush so a lost retirement is never hidden.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  // Payload storage carries no reset; validity is governed by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wptr]       <= w_norm_pkt;
      r_mem_order[r_wptr] <= r_order;
    end
  end

  // Head of queue and status outputs.
  always_comb begin
    out_pkt    = r_mem[r_rptr];
    out_order  = r_mem_order[r_rptr];
    count      = r_count;
    overflow   = r_overflow;
    drop_count = r_drop_count;
  end

endmodule : rvfi_retire_buffer
`default_nettype wire

// File: tb/tb_rvfi_retire_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvfi_retire_buffer
// Description : Directed self-checking bench for rvfi_retire_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvfi_retire_buffer;
  import psp_rvfi_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             retire_valid;
  rvfi_pkt_t        retire_pkt;
  logic             retire_ready;
  logic             out_valid;
  logic             out_ready;
  rvfi_pkt_t        out_pkt;
  logic [63:0]      out_order;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [15:0]      drop_count;

  int n_checks = 0;
  int n_errors = 0;

  rvfi_retire_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .retire_valid (retire_valid),
    .retire_pkt   (retire_pkt),
    .retire_ready (retire_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pkt      (out_pkt),
    .out_order    (out_order),
    .count        (count),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic rvfi_pkt_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                   input logic [31:0] rdw);
    rvfi_pkt_t p;
    p           = '0;
    p.insn      = 32'h0000_0013;
    p.pc_rdata  = pc;
    p.pc_wdata  = pc + 32'd4;
    p.rd_addr   = rd;
    p.rd_wdata  = rdw;
    p.mem_addr  = pc;
    p.mem_rmask = 4'h0;
    p.mem_rdata = 32'h1234_5678;
    p.mem_wmask = 4'hF;
    p.mem_wdata = 32'hCAFE_0000 | pc;
    return p;
  endfunction

  initial begin
    reset_n      = 1'b0;
    flush        = 1'b0;
    retire_valid = 1'b0;
    retire_pkt   = '0;
    out_ready    = 1'b0;
    tick();
    tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    reset_n = 1'b1;
    tick();

    // Single push to x0: rd_wdata must be zeroed, latency one cycle.
    retire_valid = 1'b1;
    retire_pkt   = mk(32'h80, 5'd0, 32'hDEAD_BEEF);
    out_ready    = 1'b1;
    tick();
    retire_valid = 1'b0;
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_out_order", out_order, 64'd0);
    check("t1_rd_wdata", 64'(out_pkt.rd_wdata), 64'd0);
    check("t1_pc", 64'(out_pkt.pc_rdata), 64'h80);
    tick();
    check("t1_count_after", 64'(count), 64'd0);
    check("t1_valid_after", 64'(out_valid), 64'd0);

    // Fresh reset, then fill the buffer with the consumer stalled.
    reset_n = 1'b0;
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      retire_valid = 1'b1;
      retire_pkt   = mk(32'h100 + 32'(4 * i), 5'd5, 32'hA0 + 32'(i));
      tick();
    end
    retire_valid = 1'b0;
    #1;
    check("t2_count", 64'(count), 64'd4);
    check("t2_retire_ready", 64'(retire_ready), 64'd0);
    check("t2_head_order", out_order, 64'd0);
    check("t2_head_pc", 64'(out_pkt.pc_rdata), 64'h100);
    check("t2_rd_wdata_kept", 64'(out_pkt.rd_wdata), 64'hA0);
    check("t2_mem_rdata_zero", 64'(out_pkt.mem_rdata), 64'd0);
    check("t2_mem_wdata_kept", 64'(out_pkt.mem_wdata), 64'hCAFE_0100);

    // Three retirements against a full, stalled buffer are dropped.
    retire_valid = 1'b1;
    retire_pkt   = mk(32'h300, 5'd1, 32'h1);
    repeat (3) tick();
    retire_valid = 1'b0;
    check("t3_overflow", 64'(overflow), 64'd1);
    check("t3_drop_count", 64'(drop_count), 64'd3);
    check("t3_count", 64'(count), 64'd4);
    check("t3_head_order", out_order, 64'd0);

    // Full buffer, simultaneous push and pop: accepted, takes order 4.
    retire_valid = 1'b1;
    retire_pkt   = mk(32'h200, 5'd2, 32'h2);
    out_ready    = 1'b1;
    #1;
    check("t4_retire_ready", 64'(retire_ready), 64'd1);
    tick();
    retire_valid = 1'b0;
    check("t4_count", 64'(count), 64'd4);
    check("t4_head_order", out_order, 64'd1);
    check("t4_head_pc", 64'(out_pkt.pc_rdata), 64'h104);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_pc;
      exp_pc = (i == 3) ? 32'h200 : 32'h104 + 32'(4 * i);
      check("t4_drain_valid", 64'(out_valid), 64'd1);
      check("t4_drain_order", out_order, 64'(i + 1));
      check("t4_drain_pc", 64'(out_pkt.pc_rdata), 64'(exp_pc));
      tick();
    end
    check("t4_empty_count", 64'(count), 64'd0);
    check("t4_empty_valid", 64'(out_valid), 64'd0);

    // Two buffered (orders 5,6), then flush with a coincident push.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      retire_valid = 1'b1;
      retire_pkt   = mk(32'h400 + 32'(4 * i), 5'd3, 32'h3);
      tick();
    end
    check("t5_count_pre", 64'(count), 64'd2);
    flush        = 1'b1;
    retire_valid = 1'b1;
    retire_pkt   = mk(32'h408, 5'd3, 32'h3);
    tick();
    flush        = 1'b0;
    retire_valid = 1'b0;
    check("t5_count", 64'(count), 64'd0);
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_overflow_kept", 64'(overflow), 64'd1);
    check("t5_drop_kept", 64'(drop_count), 64'd3);
    retire_valid = 1'b1;
    retire_pkt   = mk(32'h40C, 5'd3, 32'h3);
    tick();
    retire_valid = 1'b0;
    check("t5_next_order", out_order, 64'd7);
    check("t5_next_pc", 64'(out_pkt.pc_rdata), 64'h40C);
    check("t5_next_count", 64'(count), 64'd1);

    // Three buffered, start draining, then assert reset mid-drain.
    for (int i = 0; i < 2; i++) begin
      retire_valid = 1'b1;
      retire_pkt   = mk(32'h410 + 32'(4 * i), 5'd4, 32'h4);
      tick();
    end
    retire_valid = 1'b0;
    check("t6_count_pre", 64'(count), 64'd3);
    out_ready = 1'b1;
    tick();
    check("t6_mid_order", out_order, 64'd8);
    reset_n = 1'b0;
    #1;
    check("t6_rst_count", 64'(count), 64'd0);
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_overflow", 64'(overflow), 64'd0);
    check("t6_rst_drop", 64'(drop_count), 64'd0);
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b0;
    retire_valid = 1'b1;
    retire_pkt   = mk(32'h500, 5'd6, 32'h6);
    tick();
    retire_valid = 1'b0;
    check("t6_post_valid", 64'(out_valid), 64'd1);
    check("t6_post_order", out_order, 64'd0);
    check("t6_post_pc", 64'(out_pkt.pc_rdata), 64'h500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_rvfi_retire_buffer
`default_nettype wire

// File: doc/rvfi_retire_buffer.md
Name: rvfi_retire_buffer

Overview:
- Sits between the psp writeback/retire stage and the RVFI consumer: the psp_rvfimon monitor in simulation, or a trace port on hardware.
- Accepts one retire record per cycle, tags it with a monotonically increasing 64-bit order, normalises it to RVFI rules, and buffers it in a small FIFO.
- Presents records downstream under a valid/ready handshake.
- Detects and reports dropped retirements so the bench can fail loudly instead of silently losing order.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of buffered records
- retire_valid  input  1  retire record present this cycle
- retire_pkt  input  rvfi_pkt_t (311)  retire record
- retire_ready  output  1  buffer can accept this cycle
- out_valid  output  1  head record valid
- out_ready  input  1  consumer accepts head
- out_pkt  output  rvfi_pkt_t (311)  head record
- out_order  output  64  order tag of head record
- count  output  CNT_W  current occupancy
- overflow  output  1  sticky: a retirement was dropped
- drop_count  output  16  saturating count of dropped retirements

Behaviour:
- Reset (reset_n low, asynchronous):
  - count=0, out_valid=0, overflow=0, drop_count=0.
  - Order counter=0; read/write pointers=0.
  - out_pkt/out_order are don't-care while out_valid=0; the bench must not check them.
- Handshake:
  - push = retire_valid && retire_ready.
  - pop = out_valid && out_ready.
  - retire_ready = (count < DEPTH) || out_ready. This is a combinational path from out_ready, and it is intentional: a full buffer with a pop in the same cycle still accepts a push.
  - out_valid = (count != 0).
- Latency: a record pushed at edge N is visible at out_valid/out_pkt after edge N. There is no same-cycle bypass and minimum latency is 1 cycle.
- Order:
  - The internal 64-bit counter is stored with each record on push, then increments by 1 on every push.
  - The counter wraps modulo 2^64.
  - Dropped records never consume an order value.
- Normalisation on push:
  - If rd_addr==0, rd_wdata is stored as 0.
  - If mem_rmask==0, mem_rdata is stored as 0.
  - If mem_wmask==0, mem_wdata is stored as 0.
  - All other fields are stored verbatim.
- Occupancy:
  - count += push − pop each cycle.
  - Pointers wrap at DEPTH (mod arithmetic on log2(DEPTH) bits).
- Drop:
  - A drop occurs when retire_valid && !retire_ready.
  - On a drop: overflow←1 (sticky until reset), and drop_count increments, saturating at 16'hFFFF.
  - The dropped record is discarded.
- Flush:
  - Flush has priority over push and pop in the same cycle.
  - It sets count=0 and both pointers=0; out_valid falls the next cycle.
  - The order counter, overflow and drop_count are NOT cleared.
  - A push coincident with flush is discarded, but is not counted as a drop and does not advance order.
- Reset mid-operation: all buffered records are lost immediately. Outputs return to reset values asynchronously; no partial handshake survives.
- Storage is a register array with no reset on the payload. Only control state is reset.

Decomposition:
- Shared package psp_rvfi_pkg:
  - rvfi_pkt_t packed struct with fields: insn[32], pc_rdata[32], pc_wdata[32], rs1_addr[5], rs2_addr[5], rs1_rdata[32], rs2_rdata[32], rd_addr[5], rd_wdata[32], mem_addr[32], mem_rmask[4], mem_wmask[4], mem_rdata[32], mem_wdata[32].
  - RVFI_ORDER_W=64.
- One natural sub-module: rvfi_pkt_normalise, a combinational x0/mask zeroing function applied on push.
- FIFO storage and control stay in the top module.

Test Plan:
- Reset then a single push with rd_addr=0, rd_wdata=0xDEADBEEF, out_ready=1 → out_valid high the next cycle, out_order=0, out_pkt.rd_wdata=0; then count returns to 0.
- With out_ready=0, push 4 records with pc_rdata 0x100, 0x104, 0x108, 0x10C:
  - → count=4 and retire_ready=0.
  - Then raise out_ready → records drain in order with out_order 0,1,2,3.
- With the buffer full and out_ready=0, assert retire_valid for 3 cycles → overflow=1 and drop_count=3. The next accepted record gets out_order=4.
- With the buffer full, push and out_ready=1 in the same cycle → retire_ready=1, count stays 4, the head advances, and the new record takes the next order.
- With 2 records buffered, assert flush together with a push → count=0 and out_valid=0 next cycle. The next push gets out_order=2 and overflow is unchanged.
- Deassert reset_n mid-drain with 3 records buffered → count=0, out_valid=0 and overflow=0 immediately. After release, the first push gets out_order=0.
